// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register bank:
// FSM state encoding, R/W bit values and the frame-width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    CMD,
    DATA,
    OVERRUN
  } spi_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between a controller (master) and the register bank (slave).
interface spi_reg_bank_if;

  logic SCLK;
  logic COPI;
  logic nCS;
  logic CIPO;
  logic cipo_oe;

  modport master (
    output SCLK,
    output COPI,
    output nCS,
    input  CIPO,
    input  cipo_oe
  );

  modport slave (
    input  SCLK,
    input  COPI,
    input  nCS,
    output CIPO,
    output cipo_oe
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronised value.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resetting to 0 means a low nCS after reset never looks like a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing NUM_REGS registers; frames are
// {R/W, address, data}, MSB first, and writes commit only on a clean nCS rise.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  spi_sync_edge u_sclk (.clk(clk), .rst(rst), .async_in(spi.SCLK),
                        .sync_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_copi (.clk(clk), .rst(rst), .async_in(spi.COPI),
                        .sync_out(copi_s), .rise(copi_rise), .fall(copi_fall));
  spi_sync_edge u_ncs  (.clk(clk), .rst(rst), .async_in(spi.nCS),
                        .sync_out(ncs_s), .rise(ncs_rise), .fall(ncs_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_s, copi_rise, copi_fall};

  spi_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           bit_cnt_q;
  logic [FRAME_W-1:0]         shift_in_q, shift_nxt;
  logic                       rw_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          shift_out_q, rd_word;
  logic                       cipo_q, cipo_oe_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       start, sample, load_rd, shift_out_en;
  logic                       frame_end, commit, reject, addr_ok;

  assign shift_nxt = {shift_in_q[FRAME_W-2:0], copi_s};
  assign addr_ok   = ({1'b0, addr_q} < (ADDR_W+1)'(NUM_REGS));

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_IDLE;
    else     state_q <= state_d;
  end

  // nCS rise is checked first so a coincident SCLK edge is dropped.
  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    sample       = 1'b0;
    load_rd      = 1'b0;
    shift_out_en = 1'b0;
    frame_end    = 1'b0;
    commit       = 1'b0;
    reject       = 1'b0;
    case (state_q)
      WAIT_IDLE: if (ncs_s) state_d = IDLE;
      IDLE: begin
        if (ncs_fall) begin
          state_d = CMD;
          start   = 1'b1;
        end
      end
      CMD, DATA, OVERRUN: begin
        if (ncs_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
          if (bit_cnt_q != '0 && rw_q == RW_WRITE) begin
            if (state_q == DATA && bit_cnt_q == CNT_W'(FRAME_W) && addr_ok) commit = 1'b1;
            else reject = 1'b1;
          end else if (state_q != CMD && !addr_ok) begin
            reject = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            if (state_q == CMD) begin
              sample = 1'b1;
              if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                state_d = DATA;
                load_rd = 1'b1;
              end
            end else if (state_q == DATA) begin
              if (bit_cnt_q == CNT_W'(FRAME_W)) state_d = OVERRUN;
              else sample = 1'b1;
            end
          end
          if (sclk_fall && state_q != CMD) shift_out_en = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      rw_q        <= RW_READ;
      addr_q      <= '0;
      shift_out_q <= '0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      regs_q      <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      frame_err   <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (start) bit_cnt_q <= '0;
      if (sample) begin
        shift_in_q <= shift_nxt;
        bit_cnt_q  <= bit_cnt_q + 1'b1;
        if (bit_cnt_q == '0) rw_q <= copi_s;
      end
      // Address is latched at DATA entry for both reads and the later commit check.
      if (load_rd) begin
        addr_q <= shift_nxt[ADDR_W-1:0];
        if (rw_q == RW_READ) begin
          shift_out_q <= rd_word;
          cipo_oe_q   <= 1'b1;
        end
      end
      if (shift_out_en && cipo_oe_q) begin
        cipo_q      <= shift_out_q[DATA_W-1];
        shift_out_q <= {shift_out_q[DATA_W-2:0], 1'b0};
      end
      if (frame_end) begin
        cipo_oe_q <= 1'b0;
        cipo_q    <= 1'b0;
      end
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= shift_in_q[DATA_W-1:0];
        end
        wr_addr  <= addr_q;
        wr_valid <= 1'b1;
      end
      if (reject) frame_err <= 1'b1;
    end
  end

  assign spi.CIPO    = cipo_oe_q & cipo_q;
  assign spi.cipo_oe = cipo_oe_q;
  assign regs_flat   = regs_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: table of SPI frames with expected register image,
// plus a scoreboard of expected wr_valid/frame_err events.
module tb_spi_reg_bank;

  localparam int NUM_REGS = 5;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int RW       = NUM_REGS * DATA_W;
  localparam int NVEC     = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic [RW-1:0]   regs_flat;
  logic            wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic            frame_err;

  always #5 clk = ~clk;

  spi_reg_bank_if spi();

  spi_reg_bank #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi      (spi),
    .regs_flat(regs_flat),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .frame_err(frame_err)
  );

  typedef enum int {EV_NONE, EV_WRITE, EV_ERR} ev_e;

  typedef struct {
    ev_e               kind;
    logic [ADDR_W-1:0] addr;
  } ev_t;

  typedef struct {
    logic [31:0]       frame;
    int                nbits;
    bit                coinc;
    ev_e               exp_ev;
    logic [ADDR_W-1:0] exp_addr;
    bit                is_read;
    logic [7:0]        exp_rd;
    logic [RW-1:0]     exp_regs;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[NVEC];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   since_rise = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) since_rise++;

  // Every DUT event pops one expected event; an unexpected one is a failure.
  always @(negedge clk) begin
    if (!spi.cipo_oe && spi.CIPO !== 1'b0) checkOutput("cipo_idle", 64'(spi.CIPO), 64'd0);
    if (wr_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", {62'd0, wr_valid, frame_err}, 64'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        checkOutput("event_kind", 64'(wr_valid ? EV_WRITE : EV_ERR), 64'(e.kind));
        checkOutput("event_exclusive", 64'(wr_valid & frame_err), 64'd0);
        checkOutput("event_latency", 64'(since_rise <= 4), 64'd1);
        if (e.kind == EV_WRITE) checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
      end
    end
  end

  task automatic clockBit(input logic b, input bit ncs_with_edge, output logic cipo_b, output logic oe_b);
    spi.COPI = b;
    repeat (5) @(negedge clk);
    cipo_b = spi.CIPO;
    oe_b   = spi.cipo_oe;
    if (ncs_with_edge) begin
      spi.nCS    = 1'b1;
      since_rise = 0;
    end
    spi.SCLK = 1'b1;
    repeat (5) @(negedge clk);
    spi.SCLK = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] frame, input int nbits, input bit coinc,
                               output logic [7:0] rd, output bit oe_seen);
    logic cb, ob;
    rd      = '0;
    oe_seen = 1'b0;
    @(negedge clk);
    spi.nCS = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      clockBit(frame[nbits-1-i], coinc && (i == nbits - 1), cb, ob);
      if (i >= 8 && i < 16) begin
        rd = {rd[6:0], cb};
        oe_seen = oe_seen | ob;
      end
    end
    if (!coinc) begin
      repeat (5) @(negedge clk);
      spi.nCS    = 1'b1;
      since_rise = 0;
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    bit         oe_seen;
    logic       cb, ob;
    logic [31:0] rst_frame;

    //          frame      n   co  event     addr  rd  exp_rd  regs {r4,r3,r2,r1,r0}
    vecs[0]  = '{32'h82A5,  16, 0, EV_WRITE, 7'd2, 0, 8'h00, 40'h00_00_A5_00_00};
    vecs[1]  = '{32'h0200,  16, 0, EV_NONE,  7'd0, 1, 8'hA5, 40'h00_00_A5_00_00};
    vecs[2]  = '{32'h893C,  16, 0, EV_ERR,   7'd0, 0, 8'h00, 40'h00_00_A5_00_00};
    vecs[3]  = '{32'h0205,  10, 0, EV_ERR,   7'd0, 0, 8'h00, 40'h00_00_A5_00_00};
    vecs[4]  = '{32'h102AB, 17, 0, EV_ERR,   7'd0, 0, 8'h00, 40'h00_00_A5_00_00};
    vecs[5]  = '{32'h8155,  16, 0, EV_WRITE, 7'd1, 0, 8'h00, 40'h00_00_A5_55_00};
    vecs[6]  = '{32'h8366,  16, 1, EV_ERR,   7'd0, 0, 8'h00, 40'h00_00_A5_55_00};
    vecs[7]  = '{32'h0500,  16, 0, EV_ERR,   7'd0, 1, 8'h00, 40'h00_00_A5_55_00};
    vecs[8]  = '{32'h84FF,  16, 0, EV_WRITE, 7'd4, 0, 8'h00, 40'hFF_00_A5_55_00};
    vecs[9]  = '{32'h8512,  16, 0, EV_ERR,   7'd0, 0, 8'h00, 40'hFF_00_A5_55_00};
    vecs[10] = '{32'h0100,  16, 0, EV_NONE,  7'd0, 1, 8'h55, 40'hFF_00_A5_55_00};
    vecs[11] = '{32'h8081,  16, 0, EV_WRITE, 7'd0, 0, 8'h00, 40'hFF_00_A5_55_81};
    vecs[12] = '{32'h0400,  16, 0, EV_NONE,  7'd0, 1, 8'hFF, 40'hFF_00_A5_55_81};

    rst      = 1'b1;
    spi.SCLK = 1'b0;
    spi.COPI = 1'b0;
    spi.nCS  = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_regs", 64'(regs_flat), 64'd0);
    checkOutput("reset_wr_valid", 64'(wr_valid), 64'd0);
    checkOutput("reset_frame_err", 64'(frame_err), 64'd0);
    checkOutput("reset_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("reset_cipo", 64'(spi.CIPO), 64'd0);
    checkOutput("reset_cipo_oe", 64'(spi.cipo_oe), 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].exp_ev != EV_NONE) exp_q.push_back('{vecs[v].exp_ev, vecs[v].exp_addr});
      applyStimulus(vecs[v].frame, vecs[v].nbits, vecs[v].coinc, rd, oe_seen);
      checkOutput($sformatf("vec%0d_drain", v), 64'(exp_q.size()), 64'd0);
      checkOutput($sformatf("vec%0d_regs", v), 64'(regs_flat), 64'(vecs[v].exp_regs));
      checkOutput($sformatf("vec%0d_cipo_oe", v), 64'(oe_seen), 64'(vecs[v].is_read));
      if (vecs[v].is_read) checkOutput($sformatf("vec%0d_read", v), 64'(rd), 64'(vecs[v].exp_rd));
      exp_q.delete();
    end

    // Reset in the middle of a write frame, released with nCS still low.
    rst_frame = 32'h8377;
    @(negedge clk);
    spi.nCS = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) clockBit(rst_frame[15-i], 1'b0, cb, ob);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_regs", 64'(regs_flat), 64'd0);
    checkOutput("midrst_cipo_oe", 64'(spi.cipo_oe), 64'd0);
    checkOutput("midrst_wr_addr", 64'(wr_addr), 64'd0);
    rst = 1'b0;
    for (int i = 8; i < 16; i++) clockBit(rst_frame[15-i], 1'b0, cb, ob);
    repeat (5) @(negedge clk);
    spi.nCS    = 1'b1;
    since_rise = 0;
    repeat (8) @(negedge clk);
    checkOutput("midrst_after_regs", 64'(regs_flat), 64'd0);
    checkOutput("midrst_no_event", 64'(exp_q.size()), 64'd0);

    exp_q.push_back('{EV_WRITE, 7'd3});
    applyStimulus(rst_frame, 16, 1'b0, rd, oe_seen);
    checkOutput("postrst_drain", 64'(exp_q.size()), 64'd0);
    checkOutput("postrst_regs", 64'(regs_flat), 64'(40'h00_77_00_00_00));

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 5: number of DATA_W-bit registers, 1..2**ADDR_W.
REQ-002 Parameter ADDR_W, default 7: address field width.
REQ-003 Parameter DATA_W, default 8: register and data-field width; FRAME_W = 1+ADDR_W+DATA_W (default 16).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 SCLK  input  1  asynchronous SPI clock; mode 0 (CPOL=0, CPHA=0).
REQ-007 COPI  input  1  asynchronous controller-out data, MSB first.
REQ-008 nCS  input  1  asynchronous active-low chip select; frame boundary.
REQ-009 CIPO  output  1  peripheral-out read data.
REQ-010 cipo_oe  output  1  high while CIPO is driven (read DATA phase only).
REQ-011 regs_flat  output  NUM_REGS*DATA_W  all registers; reg i at bits [i*DATA_W +: DATA_W].
REQ-012 wr_valid  output  1  one-cycle pulse on each committed write.
REQ-013 wr_addr  output  ADDR_W  address of the last committed write.
REQ-014 frame_err  output  1  one-cycle pulse on each rejected frame.

Function
REQ-015 SCLK, COPI, nCS each pass through a 2-FF synchroniser; edges are detected on the synchronised value.
REQ-016 Frame: bit 0 sent = R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits, all MSB first.
REQ-017 COPI is sampled on the synchronised SCLK rising edge; CIPO changes only on the synchronised SCLK falling edge.
REQ-018 FSM states: WAIT_IDLE, IDLE, CMD, DATA, OVERRUN.
REQ-019 WAIT_IDLE -> IDLE when synchronised nCS is high; entered from reset.
REQ-020 IDLE -> CMD on synchronised nCS falling edge; bit counter cleared.
REQ-021 CMD -> DATA after 1+ADDR_W bits sampled; DATA -> OVERRUN on any sampled bit beyond FRAME_W.
REQ-022 Any state except WAIT_IDLE -> IDLE on synchronised nCS rising edge; if edges coincide, nCS wins and the SCLK edge is ignored.
REQ-023 Write commits only when nCS rises with exactly FRAME_W bits received, R/W=1 and address < NUM_REGS.
REQ-024 On commit: register, wr_addr and wr_valid update on the clk edge following nCS-rise detection; ≤4 clk from nCS pin rise.
REQ-025 Any other write-frame termination (short, overrun, address ≥ NUM_REGS) leaves all registers unchanged and pulses frame_err with the same timing.
REQ-026 Read: on CMD -> DATA, shift register loads reg[addr], or all zeros if addr ≥ NUM_REGS; data MSB appears on CIPO at the next SCLK falling edge, one bit per falling edge thereafter.
REQ-027 Reads never modify registers and never pulse wr_valid; read with address ≥ NUM_REGS pulses frame_err at nCS rise.
REQ-028 cipo_oe high from DATA entry of a read until nCS rise; CIPO = 0 whenever cipo_oe is low.
REQ-029 Timing contract: SCLK high and low phases each ≥ 4 clk periods; nCS setup/hold ≥ 4 clk to first/last SCLK edge.

Reset
REQ-030 While rst is high: all registers 0, wr_addr 0, wr_valid 0, frame_err 0, CIPO 0, cipo_oe 0, state WAIT_IDLE.
REQ-031 Reset mid-frame discards the frame without frame_err; the block ignores traffic until nCS is observed high.

Structure
REQ-032 Package spi_pkg holds the FSM state enum, R/W bit encodings and a FRAME_W helper function.
REQ-033 One sub-module spi_sync_edge (2-FF sync + rise/fall pulse outputs), instantiated for SCLK, COPI and nCS.

Verification
REQ-034 Write 0xA5 to addr 2 (frame 0x82A5) -> regs_flat[23:16]=0xA5, wr_valid one pulse, wr_addr=2, other registers 0.
REQ-035 After REQ-034, read addr 2 (frame 0x0200) -> cipo_oe high in DATA, CIPO shifts 1,0,1,0,0,1,0,1; registers unchanged.
REQ-036 Write 0x3C to addr 9, NUM_REGS=5 -> no register change, frame_err one pulse, wr_valid stays 0.
REQ-037 10-bit write frame, then 17-bit write frame -> both rejected with frame_err, registers unchanged; next valid 16-bit write commits.
REQ-038 rst asserted after 8 bits of a write, released while nCS low -> registers 0, remaining bits ignored, no frame_err; next full frame after nCS high commits.
REQ-039 nCS rise coincident with 16th SCLK rise -> frame treated as 15 bits, rejected with frame_err.
